// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and default bit period.
// Used by both the transmit and receive sides of the serial port.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS       = 8;
    localparam int unsigned UART_BIT_IDX_W       = $clog2(UART_DATA_BITS);
    localparam int unsigned UART_CLK_DIV_DEFAULT = 434;  // 50 MHz / 115200 baud

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } uart_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Baud counter: counts 0..CLK_DIV-1 and pulses bit_done (registered) during the
// final cycle of each bit period. restart forces the count back to 0.
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic bit_done
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_d;
    logic             bit_done_d;

    // bit_done is registered by looking at the count about to be loaded.
    always_comb begin
        cnt_d      = cnt;
        bit_done_d = 1'b0;
        if (restart || (cnt == CNT_MAX)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt + CNT_W'(1);
        end
        bit_done_d = (cnt_d == CNT_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bit_done <= 1'b0;
        end else begin
            cnt      <= cnt_d;
            bit_done <= bit_done_d;
        end
    end

endmodule

// File: rtl/uart_tx_port.sv
// UART transmitter with CPU bus write port, holding register and 8-N-1 shifter.
// Define UART_TX_PARITY_EN to insert an even parity bit between D7 and stop.
module uart_tx_port
    import uart_pkg::*;
#(
    parameter int unsigned CLK_DIV = UART_CLK_DIV_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wrn,
    input  logic [UART_DATA_BITS-1:0] data_in,
    output logic                      tbre,
    output logic                      tsre,
    output logic                      sdo,
    output logic                      tx_overrun
);

    localparam logic [UART_BIT_IDX_W-1:0] LAST_BIT = UART_BIT_IDX_W'(UART_DATA_BITS - 1);

    uart_state_e               state;
    uart_state_e               state_d;
    logic                      wrn_q;
    logic [UART_DATA_BITS-1:0] thr;
    logic [UART_DATA_BITS-1:0] thr_d;
    logic [UART_DATA_BITS-1:0] shift;
    logic [UART_DATA_BITS-1:0] shift_d;
    logic [UART_BIT_IDX_W-1:0] bit_idx;
    logic [UART_BIT_IDX_W-1:0] bit_idx_d;
    logic                      tbre_d;
    logic                      tsre_d;
    logic                      sdo_d;
    logic                      tx_overrun_d;
    logic                      wr_req;
    logic                      load;
    logic                      restart;
    logic                      bit_done;
`ifdef UART_TX_PARITY_EN
    logic                      par_q;
    logic                      par_d;
`endif

    uart_bit_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_bit_timer (
        .clk      (clk),
        .rst      (rst),
        .restart  (restart),
        .bit_done (bit_done)
    );

    // Next-state and next-output logic for the frame FSM and the bus write port.
    always_comb begin
        state_d      = state;
        thr_d        = thr;
        shift_d      = shift;
        bit_idx_d    = bit_idx;
        tbre_d       = tbre;
        tsre_d       = tsre;
        sdo_d        = sdo;
        tx_overrun_d = 1'b0;
        load         = 1'b0;
        restart      = 1'b0;
        wr_req       = wrn_q & ~wrn;
`ifdef UART_TX_PARITY_EN
        par_d        = par_q;
`endif

        unique case (state)
            S_IDLE: begin
                if (!tbre) begin
                    load = 1'b1;
                end
            end
            S_START: begin
                if (bit_done) begin
                    state_d   = S_DATA;
                    bit_idx_d = '0;
                    sdo_d     = shift[0];
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    shift_d = shift >> 1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        sdo_d   = par_q;
`else
                        state_d = S_STOP;
                        sdo_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx + UART_BIT_IDX_W'(1);
                        sdo_d     = shift_d[0];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    sdo_d   = 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (!tbre) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        tsre_d  = 1'b1;
                        sdo_d   = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                tsre_d  = 1'b1;
                sdo_d   = 1'b1;
            end
        endcase

        // Transfer THR into the shifter and start a new frame.
        if (load) begin
            state_d = S_START;
            shift_d = thr;
            tbre_d  = 1'b1;
            tsre_d  = 1'b0;
            sdo_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
            par_d   = even_parity(thr);
`endif
        end

        // Writes are judged against registered tbre, so a write in a transfer cycle is dropped.
        if (wr_req) begin
            if (tbre) begin
                thr_d  = data_in;
                tbre_d = 1'b0;
            end else begin
                tx_overrun_d = 1'b1;
            end
        end

        restart = (state_d != state) || (state == S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            wrn_q      <= 1'b1;
            thr        <= '0;
            shift      <= '0;
            bit_idx    <= '0;
            tbre       <= 1'b1;
            tsre       <= 1'b1;
            sdo        <= 1'b1;
            tx_overrun <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state      <= state_d;
            wrn_q      <= wrn;
            thr        <= thr_d;
            shift      <= shift_d;
            bit_idx    <= bit_idx_d;
            tbre       <= tbre_d;
            tsre       <= tsre_d;
            sdo        <= sdo_d;
            tx_overrun <= tx_overrun_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_port.sv
// Directed self-checking bench for uart_tx_port at CLK_DIV=4.
// Covers idle reset state, single frame, back-to-back frames, overrun, mid-frame reset and parity.
module tb_uart_tx_port;

    localparam int unsigned DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wrn;
    logic [7:0] data_in;
    logic       tbre;
    logic       tsre;
    logic       sdo;
    logic       tx_overrun;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx_port #(
        .CLK_DIV (DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wrn        (wrn),
        .data_in    (data_in),
        .tbre       (tbre),
        .tsre       (tsre),
        .sdo        (sdo),
        .tx_overrun (tx_overrun)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sdo"}, sdo, 1'b1);
        chk({tag, "_tbre"}, tbre, 1'b1);
        chk({tag, "_tsre"}, tsre, 1'b1);
        chk({tag, "_ovr"}, tx_overrun, 1'b0);
    endtask

    // Called when sampling the first cycle of a start bit; checks every cycle of
    // the frame and optionally issues up to two bus writes at given cycle offsets.
    task automatic expect_frame(input logic [7:0] b, input int rel_at,
                                input int wa0, input logic [7:0] wb0, input logic wo0,
                                input int wa1, input logic [7:0] wb1, input logic wo1);
        logic fb [11];
        logic tb_exp;
        logic ov_exp;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
        fb[9]  = (NB == 11) ? ^b : 1'b1;
        fb[10] = 1'b1;
        tb_exp = 1'b1;
        for (int n = 0; n < NB * int'(DIV); n++) begin
            ov_exp = 1'b0;
            if (wa0 >= 0 && n == wa0 + 1) begin tb_exp = 1'b0; ov_exp = wo0; end
            if (wa1 >= 0 && n == wa1 + 1) begin tb_exp = 1'b0; ov_exp = wo1; end
            chk($sformatf("sdo_b%0h_c%0d", b, n), sdo, fb[n / int'(DIV)]);
            chk($sformatf("tsre_b%0h_c%0d", b, n), tsre, 1'b0);
            chk($sformatf("tbre_b%0h_c%0d", b, n), tbre, tb_exp);
            chk($sformatf("ovr_b%0h_c%0d", b, n), tx_overrun, ov_exp);
            if (n == rel_at || (wa0 >= 0 && n == wa0 + 1) || (wa1 >= 0 && n == wa1 + 1)) wrn = 1'b1;
            if (wa0 >= 0 && n == wa0) begin wrn = 1'b0; data_in = wb0; end
            if (wa1 >= 0 && n == wa1) begin wrn = 1'b0; data_in = wb1; end
            tick();
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        data_in = b;
        wrn     = 1'b0;
        tick();
        chk("wr_tbre", tbre, 1'b0);
        chk("wr_tsre", tsre, 1'b1);
        chk("wr_sdo", sdo, 1'b1);
        wrn = 1'b1;
        tick();
    endtask

    initial begin
        rst     = 1'b1;
        wrn     = 1'b1;
        data_in = 8'h00;
        #1;
        chk_idle("rst_async");
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 1000; i++) begin
            chk_idle("idle");
            tick();
        end

        // Single frame 0xA5, wrn held low for a few cycles (one write only).
        data_in = 8'hA5;
        wrn     = 1'b0;
        tick();
        chk("a5_tbre", tbre, 1'b0);
        chk("a5_tsre", tsre, 1'b1);
        chk("a5_sdo", sdo, 1'b1);
        tick();
        expect_frame(8'hA5, 2, -1, 8'h00, 1'b0, -1, 8'h00, 1'b0);
        chk_idle("a5_end");
        repeat (5) tick();

        // Back-to-back 0x3C then 0xC3, with 0xFF dropped as overrun.
        write_byte(8'h3C);
        expect_frame(8'h3C, -1, 8, 8'hC3, 1'b0, 20, 8'hFF, 1'b1);
        expect_frame(8'hC3, -1, -1, 8'h00, 1'b0, -1, 8'h00, 1'b0);
        for (int i = 0; i < 60; i++) begin
            chk_idle("b2b_after");
            tick();
        end

        // Reset in the middle of data bit 3 of 0x00.
        write_byte(8'h00);
        for (int n = 0; n < 18; n++) begin
            chk("z_sdo", sdo, 1'b0);
            tick();
        end
        #1;
        rst = 1'b1;
        #1;
        chk_idle("midrst");
        tick();
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            chk_idle("post_rst");
            tick();
        end

`ifdef UART_TX_PARITY_EN
        // Parity frames: 0x07 carries parity 1, 0x03 carries parity 0.
        write_byte(8'h07);
        expect_frame(8'h07, -1, -1, 8'h00, 1'b0, -1, 8'h00, 1'b0);
        chk_idle("p07_end");
        tick();
        write_byte(8'h03);
        expect_frame(8'h03, -1, -1, 8'h00, 1'b0, -1, 8'h00, 1'b0);
        chk_idle("p03_end");
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx_port.md
# uart_tx_port

Transmit half of the on-board UART as seen from the CPU-side parallel bus: accepts a byte on an active-low write strobe, buffers it in a transmit holding register (THR), and shifts it out on the serial line as an 8-N-1 frame (optional even parity). It is the responder to the `rdn`/`wrn` bus master in the serial-connection top level and drives the `tbre`/`tsre` status flags that master polls before writing.

## Interface
- `CLK_DIV`, default 434: CLK cycles per serial bit (50 MHz / 115200); legal range ≥ 2.
- `CLK`  in  1  system clock; all logic on rising edge.
- `RST`  in  1  asynchronous, active-high reset.
- `wrn`  in  1  active-low write strobe, synchronous to `CLK`; a write is its 1→0 transition.
- `data_in`  in  8  byte to transmit, valid in the cycle `wrn` is first sampled low.
- `tbre`  out  1  THR empty; 1 = a write will be accepted.
- `tsre`  out  1  shift register empty; 1 = line idle, no frame in progress.
- `sdo`  out  1  serial data out, idle high.
- `tx_overrun`  out  1  one-cycle pulse: write dropped because THR was full.

## Operation
- Reset values: `tbre`=1, `tsre`=1, `sdo`=1, `tx_overrun`=0, THR=0, state IDLE, bit counter 0, baud counter 0.
- Write detect: registered copy `wrn_q` (reset 1); write = `wrn_q`=1 and `wrn`=0. Holding `wrn` low for many cycles is a single write.
- Write with `tbre`=1: THR←`data_in`, `tbre`←0. Write with `tbre`=0: THR unchanged, `tx_overrun`=1 for one cycle.
- Transfer: when `tbre`=0 and shifter is IDLE, next edge loads shifter from THR, `tbre`←1, `tsre`←0, state START.
- FSM states IDLE, START, DATA, PARITY (only if configured), STOP; each non-IDLE state holds one bit for exactly `CLK_DIV` cycles.
  - START: `sdo`=0. → DATA.
  - DATA: `sdo`=shift[0], LSB first; shift right after each bit; after 8 bits → PARITY or STOP.
  - PARITY: `sdo`=XOR of the 8 data bits (even parity). → STOP.
  - STOP: `sdo`=1. At end: if `tbre`=0, transfer THR and go to START directly (back-to-back, no idle bit); else → IDLE, `tsre`←1.
- Baud counter counts 0..`CLK_DIV`-1, resets on every state change; width `$clog2(CLK_DIV)`.
- Write in the same cycle as a transfer: evaluated against registered `tbre` (0) → dropped, overrun pulse.
- `sdo` is registered; no combinational path from inputs to any output.

## Timing
- Write sampled at edge k → `tbre`=0 after k → transfer at k+1: `tbre`=1, `tsre`=0, `sdo`=0 after k+1.
- Frame length: 10·`CLK_DIV` cycles (11·`CLK_DIV` with parity); `tsre` returns to 1 at the edge ending the stop bit.
- Back-to-back: next start bit begins on the same edge the previous stop bit ends.
- `RST` asserted mid-frame: outputs take reset values immediately (asynchronously); partial frame is aborted, THR contents discarded.

## Configuration
- `UART_TX_PARITY_EN` defined: PARITY state compiled in, even parity bit between D7 and stop, frame 11 bits.
- Undefined: no PARITY state, no parity logic, 8-N-1 frame of 10 bits.

## Structure
- Shared package `uart_pkg`: state enum (IDLE, START, DATA, PARITY, STOP), `UART_DATA_BITS`=8, default `CLK_DIV` constant, shared with the receive side.
- One sub-module: `uart_bit_timer` — baud counter with `restart` input and `bit_done` pulse output, parameterised by `CLK_DIV`.

## Test plan
- Reset, no writes → `sdo`=1, `tbre`=1, `tsre`=1, `tx_overrun`=0 for 1000 cycles.
- `CLK_DIV`=4, write 0xA5 → `sdo` sequence 0,1,0,1,0,0,1,0,1,1 each 4 cycles; `tsre`=1 exactly 40 cycles after start bit begins.
- Write 0x3C, then 0xC3 while first frame shifts → `tbre` low then high at transfer; second start bit immediately follows first stop bit, 80 cycles total with no idle gap.
- With THR and shifter full, write 0xFF → `tx_overrun` high one cycle; transmitted bytes are only the first two.
- Assert `RST` during data bit 3 of 0x00 → `sdo`=1 within the reset cycle, `tbre`=`tsre`=1; after release no residual frame is sent.
- With `UART_TX_PARITY_EN`, write 0x07 → parity bit 1, frame 11 bits; write 0x03 → parity bit 0.
